mux_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 8-to-1 multiplexer in the mux/counter lab datapath. It accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the 3-bit select through all eight positions at a programmable rate, so the mux output serialises the word one bit per window. A strobe marks the cycle on which the downstream consumer must sample the mux output, and a done pulse closes each word.

---
 rtl/mux_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// Module   : mux_scan_ctrl
// Brief    : Holds a byte on the 8:1 mux inputs and scans its select line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_scan_ctrl #(
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic [7:0] x,
    output logic [2:0] sel,
    output logic       busy,
    output logic       bit_strobe,
    output logic       done
);

    localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST_CNT  = CW'(DIV - 1);
    localparam logic [2:0]      START_SEL = MSB_FIRST ? 3'd7 : 3'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    x_q, x_d;
    logic [2:0]    sel_q, sel_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;

    logic          w_last_cnt;
    assign w_last_cnt = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            x_q        <= 8'h00;
            sel_q      <= START_SEL;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            x_q        <= x_d;
            sel_q      <= sel_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_SCAN;
            S_SCAN: begin
                if (abort)                             state_d = S_IDLE;
                else if (w_last_cnt && bit_q == 3'd7)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, held word and select; sel freezes on the last index of a scan.
    always_comb begin
        cnt_d = cnt_q;
        bit_d = bit_q;
        x_d   = x_q;
        sel_d = sel_q;
        case (state_q)
            S_IDLE: begin
                sel_d = START_SEL;
                if (in_valid) begin
                    x_d   = in_data;
                    cnt_d = '0;
                    bit_d = 3'd0;
                end
            end
            S_SCAN: begin
                if (abort) begin
                    sel_d = START_SEL;
                    cnt_d = '0;
                    bit_d = 3'd0;
                end else if (w_last_cnt) begin
                    cnt_d = '0;
                    if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
                        sel_d = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            default: sel_d = START_SEL;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d == S_SCAN);
        done_d     = (state_d == S_DONE);
        strobe_d   = (state_d == S_SCAN) && (cnt_d == LAST_CNT);
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bit_strobe = strobe_q;
    assign x          = x_q;
    assign sel        = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// Module   : tb_mux_scan_ctrl
// Brief    : Directed checks of mux_scan_ctrl in LSB/DIV=4 and MSB/DIV=1 builds.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, a_abort, b_abort;
    logic       a_in_ready, a_busy, a_strobe, a_done;
    logic       b_in_ready, b_busy, b_strobe, b_done;
    logic [7:0] a_x, b_x;
    logic [2:0] a_sel, b_sel;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.DIV(4), .MSB_FIRST(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_in_ready), .abort(a_abort), .x(a_x), .sel(a_sel),
        .busy(a_busy), .bit_strobe(a_strobe), .done(a_done)
    );

    mux_scan_ctrl #(.DIV(1), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_in_ready), .abort(b_abort), .x(b_x), .sel(b_sel),
        .busy(b_busy), .bit_strobe(b_strobe), .done(b_done)
    );

    // {in_ready, busy, bit_strobe, done, sel}
    logic [6:0] a_vec, b_vec;
    logic       a_mux, b_mux;
    assign a_vec = {a_in_ready, a_busy, a_strobe, a_done, a_sel};
    assign b_vec = {b_in_ready, b_busy, b_strobe, b_done, b_sel};
    assign a_mux = a_x[a_sel];
    assign b_mux = b_x[b_sel];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_abort = 1'b0; b_abort = 1'b0;
        a_data = 8'h00; b_data = 8'h00;
        #1;
        total_cnt++;
        if (a_vec !== 7'b1000_000) $display("FAIL reset_a_ctrl: got %b expected %b", a_vec, 7'b1000_000);
        else pass_cnt++;
        total_cnt++;
        if (b_vec !== 7'b1000_111) $display("FAIL reset_b_ctrl: got %b expected %b", b_vec, 7'b1000_111);
        else pass_cnt++;
        total_cnt++;
        if (a_x !== 8'h00 || b_x !== 8'h00) $display("FAIL reset_x: got %h/%h expected 00/00", a_x, b_x);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        total_cnt++;
        if (a_vec !== 7'b1000_000) $display("FAIL idle_a_ctrl: got %b expected %b", a_vec, 7'b1000_000);
        else pass_cnt++;
    endtask

    task automatic test_lsb_scan;
        logic [7:0] pat;
        logic [6:0] exp;
        pat = 8'hA5;
        a_data = pat; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        total_cnt++;
        if (a_x !== pat) $display("FAIL lsb_x: got %h expected %h", a_x, pat);
        else pass_cnt++;
        for (int c = 1; c <= 34; c++) begin
            if (c <= 32)      exp = {1'b0, 1'b1, (c % 4 == 0), 1'b0, 3'((c - 1) / 4)};
            else if (c == 33) exp = 7'b0001_111;
            else              exp = 7'b1000_000;
            total_cnt++;
            if (a_vec !== exp) $display("FAIL lsb_ctrl c=%0d: got %b expected %b", c, a_vec, exp);
            else pass_cnt++;
            if (c <= 32 && c % 4 == 0) begin
                total_cnt++;
                if (a_mux !== pat[(c - 1) / 4])
                    $display("FAIL lsb_bit c=%0d: got %b expected %b", c, a_mux, pat[(c - 1) / 4]);
                else pass_cnt++;
            end
            if (c < 34) step();
        end
    endtask

    task automatic test_msb_div1;
        logic [7:0] pat;
        logic [6:0] exp;
        pat = 8'h3C;
        b_data = pat; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 8)      exp = {1'b0, 1'b1, 1'b1, 1'b0, 3'(8 - c)};
            else if (c == 9) exp = 7'b0001_000;
            else             exp = 7'b1000_111;
            total_cnt++;
            if (b_vec !== exp) $display("FAIL msb_ctrl c=%0d: got %b expected %b", c, b_vec, exp);
            else pass_cnt++;
            if (c <= 8) begin
                total_cnt++;
                if (b_mux !== pat[8 - c])
                    $display("FAIL msb_bit c=%0d: got %b expected %b", c, b_mux, pat[8 - c]);
                else pass_cnt++;
            end
            if (c < 10) step();
        end
    endtask

    task automatic test_back_to_back;
        int acc[2];
        int n_acc;
        bit chk1;
        n_acc = 0; chk1 = 1'b0;
        acc[0] = 0; acc[1] = 0;
        a_data = 8'h01; a_valid = 1'b1;
        for (int c = 0; c < 120 && n_acc < 2; c++) begin
            if (a_in_ready) begin
                acc[n_acc] = c;
                n_acc++;
            end
            step();
            if (n_acc == 1) begin
                if (!chk1) begin
                    chk1 = 1'b1;
                    total_cnt++;
                    if (a_x !== 8'h01) $display("FAIL b2b_x1: got %h expected 01", a_x);
                    else pass_cnt++;
                end
                a_data = 8'h80;
            end
        end
        a_valid = 1'b0;
        total_cnt++;
        if (n_acc != 2) $display("FAIL b2b_timeout: got %0d accepts expected 2", n_acc);
        else pass_cnt++;
        total_cnt++;
        if (acc[1] - acc[0] != 34) $display("FAIL b2b_gap: got %0d expected 34", acc[1] - acc[0]);
        else pass_cnt++;
        total_cnt++;
        if (a_x !== 8'h80 || a_busy !== 1'b1) $display("FAIL b2b_x2: got %h busy %b expected 80 busy 1", a_x, a_busy);
        else pass_cnt++;
        for (int c = 0; c < 60 && !a_in_ready; c++) step();
        total_cnt++;
        if (a_in_ready !== 1'b1) $display("FAIL b2b_idle: got %b expected 1", a_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        bit seen;
        a_data = 8'hC3; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        repeat (9) step();
        total_cnt++;
        if (a_vec !== 7'b0100_010) $display("FAIL abort_pre: got %b expected %b", a_vec, 7'b0100_010);
        else pass_cnt++;
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        total_cnt++;
        if (a_vec !== 7'b1000_000) $display("FAIL abort_ctrl: got %b expected %b", a_vec, 7'b1000_000);
        else pass_cnt++;
        total_cnt++;
        if (a_x !== 8'hC3) $display("FAIL abort_x: got %h expected c3", a_x);
        else pass_cnt++;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (a_strobe || a_done || a_busy) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_quiet: got activity %b expected 0", seen);
        else pass_cnt++;

        a_data = 8'h5A; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        a_data = 8'hE7;
        repeat (9) step();
        a_valid = 1'b1; a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        total_cnt++;
        if (a_in_ready !== 1'b1 || a_x !== 8'h5A)
            $display("FAIL abort_hold: got rdy %b x %h expected rdy 1 x 5a", a_in_ready, a_x);
        else pass_cnt++;
        step();
        a_valid = 1'b0;
        total_cnt++;
        if (a_busy !== 1'b1 || a_x !== 8'hE7 || a_sel !== 3'd0)
            $display("FAIL abort_next: got busy %b x %h sel %0d expected 1 e7 0", a_busy, a_x, a_sel);
        else pass_cnt++;
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        total_cnt++;
        if (a_vec !== 7'b1000_000) $display("FAIL abort_clean: got %b expected %b", a_vec, 7'b1000_000);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit seen;
        a_data = 8'hFF; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        repeat (17) step();
        total_cnt++;
        if (a_vec !== 7'b0100_100) $display("FAIL rmid_pre: got %b expected %b", a_vec, 7'b0100_100);
        else pass_cnt++;
        #3 rst = 1'b1;
        #1;
        total_cnt++;
        if (a_vec !== 7'b1000_000 || a_x !== 8'h00)
            $display("FAIL rmid_a: got %b x %h expected %b x 00", a_vec, a_x, 7'b1000_000);
        else pass_cnt++;
        total_cnt++;
        if (b_vec !== 7'b1000_111 || b_x !== 8'h00)
            $display("FAIL rmid_b: got %b x %h expected %b x 00", b_vec, b_x, 7'b1000_111);
        else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            step();
            if (a_done || a_busy || a_strobe) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL rmid_quiet: got activity %b expected 0", seen);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lsb_scan();
        test_msb_div1();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
